irq_pending_ctrl: RTL
=====================

Name: irq_pending_ctrl

Overview:
Interrupt front-end that sits directly upstream of the 8-to-3 priority encoding stage and owns the sequential part of interrupt delivery. It captures rising edges on 8 request lines into sticky pending bits and applies an enable mask. It selects the highest-index eligible request and presents its 3-bit ID on a valid/ack handshake. On acknowledge it clears only the serviced pending bit.

Parameters:
N_IRQ, 8, number of request lines; fixed at 8 in this revision.
ID_W, 3, width of irq_id; equals clog2(N_IRQ).

Ports:
clk       input   1      system clock, rising-edge active
rst       input   1      synchronous, active-high reset
irq_in    input   8      raw request lines, synchronous to clk; bit 7 = highest priority
mask      input   8      per-line enable; 1 = eligible for delivery
irq_ack   input   1      consumer accepts the presented ID
irq_valid output  1      registered; irq_id is meaningful
irq_id    output  3      registered ID of the presented request
pending   output  8      registered sticky pending bits

Behaviour:
- Interface (already decided): one clock, clk. Reset rst is synchronous and active-high.
- Reset values: pending=8'h00, irq_valid=0, irq_id=3'b000, state=IDLE, prev_in=8'hFF.
  - prev_in=8'hFF means lines already high at reset release do not create events.
- Edge detect: edge = irq_in & ~prev_in. prev_in <= irq_in every cycle.
- Pending update each cycle:
  - pending <= (pending & ~clr) | edge.
  - clr is the one-hot bit of irq_id when (state==PRESENT && irq_ack), otherwise 0.
  - If set and clear hit the same bit in the same cycle, set wins, so the new event is retained.
- Pending bits are set regardless of mask. The eligible set is pending & mask.
- State machine:
  - IDLE: if eligible != 0, then irq_id <= index of the highest set eligible bit, irq_valid <= 1, go to PRESENT. Otherwise stay in IDLE.
  - PRESENT: irq_id and irq_valid are held stable until irq_ack=1. On ack: irq_valid <= 0, go to IDLE.
- Minimum one-cycle gap with irq_valid=0 between successive deliveries.
- No preemption: a higher-priority edge or a mask change during PRESENT does not alter irq_id. The presented request stays valid until acked, even if masked.
- irq_ack while irq_valid=0 is ignored, with no pending change.
- Latency:
  - irq_in rising edge sampled at clock edge t sets pending after t.
  - irq_valid rises after edge t+1, i.e. 2 cycles from input rise to presentation when the block is idle.
- Masked pending bits persist. They are delivered once unmasked, via the IDLE path.
- rst asserted mid-handshake: all state returns to reset values on that edge. In-flight and pending requests are discarded.

Optional Feature:
- Macro: IRQ_OVERRUN_EN.
- When defined: adds output port overrun [7:0], registered, reset 8'h00.
  - overrun[i] <= 1 when edge[i] && pending[i] && !clr[i], meaning a second event arrived before service.
  - overrun[i] is cleared in the cycle bit i is acked. If a new overrun condition occurs in that same cycle, set wins.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package irq_pkg: N_IRQ=8, ID_W=3, state enum {IDLE, PRESENT}, RST_PREV constant 8'hFF.
- Sub-module irq_prio_pick (combinational):
  - Inputs: 8-bit eligible vector.
  - Outputs: 3-bit highest-set index and an any-set flag.
  - Instantiated once.

Test Plan:
- Reset with irq_in=8'h01, mask=8'hFF, then hold for 5 cycles -> pending=8'h00 and irq_valid=0 throughout, since there is no edge.
- Rise irq_in[3], mask=8'hFF -> pending=8'h08 after 1 cycle. irq_valid=1 with irq_id=3 after 2 cycles. Pulse irq_ack -> pending=8'h00, irq_valid=0 next cycle.
- Rise bits 1 and 6 together -> irq_id=6 first. After ack and a 1-cycle gap, irq_id=1. Then pending=8'h00.
- While presenting irq_id=2, rise bit 7 -> irq_id stays 2 until ack, then irq_id=7 is presented.
- mask=8'h00, rise bit 5 -> pending=8'h20 and irq_valid stays 0. Set mask=8'h20 -> irq_valid=1, irq_id=5 one cycle later.
- With IRQ_OVERRUN_EN: bit 4 pending and unacked, then a second rise on bit 4 -> overrun=8'h10. Ack of ID 4 clears overrun to 8'h00. A re-rise of bit 4 in the ack cycle leaves pending[4]=1.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared constants and types for the interrupt pending/delivery front-end.
package irq_pkg;
  localparam int N_IRQ = 8;
  localparam int ID_W  = 3;

  // All-ones so lines already high when reset releases do not look like edges.
  localparam logic [N_IRQ-1:0] RST_PREV = 8'hFF;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } irq_state_e;
endpackage

// File: rtl/irq_prio_pick.sv
// Combinational highest-index picker: bit N_IRQ-1 has the highest priority.
module irq_prio_pick
  import irq_pkg::*;
(
  input  logic [N_IRQ-1:0] elig,
  output logic [ID_W-1:0]  idx,
  output logic             any
);
  // Ascending scan: later (higher) set bits overwrite earlier ones.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (elig[i]) begin
        idx = ID_W'(i);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/irq_pending_ctrl.sv
// Edge capture, sticky pending bits, masking and valid/ack delivery of the top IRQ ID.
// Optional IRQ_OVERRUN_EN adds a sticky per-line overrun flag output.
module irq_pending_ctrl
  import irq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic [N_IRQ-1:0] mask,
  input  logic             irq_ack,
  output logic             irq_valid,
  output logic [ID_W-1:0]  irq_id,
`ifdef IRQ_OVERRUN_EN
  output logic [N_IRQ-1:0] overrun,
`endif
  output logic [N_IRQ-1:0] pending
);
  irq_state_e       state, state_nxt;
  logic [N_IRQ-1:0] prev_in;
  logic [N_IRQ-1:0] edge_det;
  logic [N_IRQ-1:0] clr;
  logic [N_IRQ-1:0] elig;
  logic [ID_W-1:0]  pick_id;
  logic             pick_any;
  logic             valid_nxt;
  logic [ID_W-1:0]  id_nxt;

  assign edge_det = irq_in & ~prev_in;
  assign elig     = pending & mask;
  // Only an ack against a presented ID clears anything; a stray ack is a no-op.
  assign clr      = (state == PRESENT && irq_ack) ? (N_IRQ'(1) << irq_id) : '0;

  irq_prio_pick u_pick (
    .elig (elig),
    .idx  (pick_id),
    .any  (pick_any)
  );

  always_comb begin
    state_nxt = state;
    valid_nxt = irq_valid;
    id_nxt    = irq_id;
    case (state)
      IDLE: begin
        if (pick_any) begin
          id_nxt    = pick_id;
          valid_nxt = 1'b1;
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        // No preemption: ID is frozen until acked, even if its mask drops.
        if (irq_ack) begin
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        valid_nxt = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      prev_in   <= RST_PREV;
      pending   <= '0;
      irq_valid <= 1'b0;
      irq_id    <= '0;
    end else begin
      state     <= state_nxt;
      prev_in   <= irq_in;
      // Set after clear so a fresh event on the serviced line survives.
      pending   <= (pending & ~clr) | edge_det;
      irq_valid <= valid_nxt;
      irq_id    <= id_nxt;
    end
  end

`ifdef IRQ_OVERRUN_EN
  always_ff @(posedge clk) begin
    if (rst) overrun <= '0;
    else     overrun <= (overrun & ~clr) | (edge_det & pending & ~clr);
  end
`endif
endmodule
